vehicle_demand_tracker: RTL and testbench

- Upstream stage of the NS/EW traffic signal FSM. Conditions two raw inductive-loop sensors (one per direction) and produces its cars_ns/cars_ew request inputs.
- Per lane: 2-FF synchronise, debounce, count arrivals, estimate departures while that lane is green, and flag stuck-on sensors.
- A stuck sensor fails safe: the lane's request is forced high.

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/vehicle_lane_detector.sv | 183 ++++++++++++++++++
 rtl/vehicle_demand_tracker.sv | 64 ++++++
 tb/tb_vehicle_demand_tracker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: definitions shared by the traffic-signal codebase.
//   - Lane detector states (ABSENT / PRESENT / STUCK).
//   - Signal FSM state encodings.
//   - Synchroniser depth and width of the internal cycle timers.
package traffic_pkg;

  // Flops in each raw-sensor synchroniser chain.
  localparam int SYNC_STAGES = 2;

  // Width of the debounce, presence and departure timers.
  localparam int TIMER_W = 16;

  // Per-lane vehicle presence state.
  typedef enum logic [1:0] {
    ABSENT  = 2'd0,
    PRESENT = 2'd1,
    STUCK   = 2'd2
  } lane_state_e;

  // Downstream NS/EW signal controller states.
  typedef enum logic [1:0] {
    SIG_NS_GREEN  = 2'd0,
    SIG_NS_YELLOW = 2'd1,
    SIG_EW_GREEN  = 2'd2,
    SIG_EW_YELLOW = 2'd3
  } sig_state_e;

endpackage

// File: rtl/vehicle_lane_detector.sv
// vehicle_lane_detector: conditioning and demand estimation for one lane.
//   clk, rst : clock, asynchronous active-high reset
//   loop     : raw inductive-loop sensor (asynchronous, bouncy)
//   green    : this lane's green from the signal FSM (synchronous)
//   cars     : demand request (queue non-empty or sensor stuck)
//   queue    : estimated vehicles waiting, saturating at QUEUE_MAX
//   fault    : sensor stuck-on flag
module vehicle_lane_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPART_CYCLES   = 5,
  parameter int QUEUE_MAX       = 15,
  parameter int STUCK_CYCLES    = 200,
  parameter int QW              = $clog2(QUEUE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          loop,
  input  logic          green,
  output logic          cars,
  output logic [QW-1:0] queue,
  output logic          fault
);

  localparam logic [TIMER_W-1:0] T_ZERO     = TIMER_W'(0);
  localparam logic [TIMER_W-1:0] T_ONE      = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] DB_LAST    = TIMER_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DEP_LAST   = TIMER_W'(DEPART_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STUCK_LAST = TIMER_W'(STUCK_CYCLES - 1);
  localparam logic [QW-1:0]      Q_ZERO     = QW'(0);
  localparam logic [QW-1:0]      Q_ONE      = QW'(1);
  localparam logic [QW-1:0]      Q_MAX      = QW'(QUEUE_MAX);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic                   deb_r;
  logic                   deb_d_r;
  logic [TIMER_W-1:0]     db_cnt_r;
  lane_state_e            state_r;
  lane_state_e            state_next_s;
  logic [TIMER_W-1:0]     pres_cnt_r;
  logic [TIMER_W-1:0]     pres_cnt_next_s;
  logic                   fault_r;
  logic                   fault_next_s;
  logic [TIMER_W-1:0]     dep_cnt_r;
  logic [QW-1:0]          queue_r;
  logic                   arrival_s;
  logic                   dep_run_s;
  logic                   depart_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous loop input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], loop};
    end
  end

  // Debounce: the level must disagree for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_r    <= 1'b0;
      db_cnt_r <= T_ZERO;
    end else if (sync_s == deb_r) begin
      db_cnt_r <= T_ZERO;
    end else if (db_cnt_r == DB_LAST) begin
      deb_r    <= sync_s;
      db_cnt_r <= T_ZERO;
    end else begin
      db_cnt_r <= db_cnt_r + T_ONE;
    end
  end

  // Delayed debounced level for rising-edge (arrival) detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_d_r <= 1'b0;
    end else begin
      deb_d_r <= deb_r;
    end
  end

  // Both terms are flops, so the arrival pulse is clean for one cycle.
  assign arrival_s = deb_r & ~deb_d_r;

  // Lane FSM state register, presence timer and fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ABSENT;
      pres_cnt_r <= T_ZERO;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      pres_cnt_r <= pres_cnt_next_s;
      fault_r    <= fault_next_s;
    end
  end

  // Lane FSM next-state and presence-timer logic.
  always_comb begin
    state_next_s    = state_r;
    pres_cnt_next_s = pres_cnt_r;
    case (state_r)
      ABSENT: begin
        if (deb_r) begin
          state_next_s    = PRESENT;
          pres_cnt_next_s = T_ZERO;
        end else begin
          state_next_s    = ABSENT;
        end
      end
      PRESENT: begin
        if (!deb_r) begin
          state_next_s = ABSENT;
        end else if (pres_cnt_r == STUCK_LAST) begin
          state_next_s = STUCK;
        end else begin
          pres_cnt_next_s = pres_cnt_r + T_ONE;
        end
      end
      STUCK: begin
        if (!deb_r) begin
          state_next_s = ABSENT;
        end else begin
          state_next_s = STUCK;
        end
      end
      default: begin
        state_next_s    = ABSENT;
        pres_cnt_next_s = T_ZERO;
      end
    endcase
  end

  // Lane FSM output: decoded from the next state so the flop tracks STUCK exactly.
  always_comb begin
    fault_next_s = (state_next_s == STUCK);
  end

  // Departures are only estimated while green and something is queued.
  assign dep_run_s = green & (queue_r != Q_ZERO);
  assign depart_s  = dep_run_s & (dep_cnt_r == DEP_LAST);

  // Departure timer: cleared whenever it is not running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dep_cnt_r <= T_ZERO;
    end else if (!dep_run_s || depart_s) begin
      dep_cnt_r <= T_ZERO;
    end else begin
      dep_cnt_r <= dep_cnt_r + T_ONE;
    end
  end

  // Queue count: arrivals up (saturating), departures down; both cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      queue_r <= Q_ZERO;
    end else begin
      case ({arrival_s, depart_s})
        2'b10: begin
          if (queue_r != Q_MAX) begin
            queue_r <= queue_r + Q_ONE;
          end else begin
            queue_r <= queue_r;
          end
        end
        2'b01:   queue_r <= queue_r - Q_ONE;
        default: queue_r <= queue_r;
      endcase
    end
  end

  // A stuck sensor fails safe by holding the request high.
  assign cars  = (queue_r != Q_ZERO) | fault_r;
  assign queue = queue_r;
  assign fault = fault_r;

endmodule

// File: rtl/vehicle_demand_tracker.sv
// vehicle_demand_tracker: demand front end for the NS/EW signal FSM.
//   clk, rst           : clock, asynchronous active-high reset
//   loop_ns, loop_ew   : raw loop sensors (asynchronous, bouncy)
//   green_N, green_E   : lane greens from the signal FSM
//   cars_ns, cars_ew   : demand requests to the signal FSM
//   queue_ns, queue_ew : estimated vehicle counts
//   fault_ns, fault_ew : sensor stuck-on flags
// The two lanes are independent instances of vehicle_lane_detector.
module vehicle_demand_tracker
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPART_CYCLES   = 5,
  parameter int QUEUE_MAX       = 15,
  parameter int STUCK_CYCLES    = 200,
  parameter int QW              = $clog2(QUEUE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          loop_ns,
  input  logic          loop_ew,
  input  logic          green_N,
  input  logic          green_E,
  output logic          cars_ns,
  output logic          cars_ew,
  output logic [QW-1:0] queue_ns,
  output logic [QW-1:0] queue_ew,
  output logic          fault_ns,
  output logic          fault_ew
);

  vehicle_lane_detector #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEPART_CYCLES  (DEPART_CYCLES),
    .QUEUE_MAX      (QUEUE_MAX),
    .STUCK_CYCLES   (STUCK_CYCLES),
    .QW             (QW)
  ) u_lane_ns (
    .clk  (clk),
    .rst  (rst),
    .loop (loop_ns),
    .green(green_N),
    .cars (cars_ns),
    .queue(queue_ns),
    .fault(fault_ns)
  );

  vehicle_lane_detector #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEPART_CYCLES  (DEPART_CYCLES),
    .QUEUE_MAX      (QUEUE_MAX),
    .STUCK_CYCLES   (STUCK_CYCLES),
    .QW             (QW)
  ) u_lane_ew (
    .clk  (clk),
    .rst  (rst),
    .loop (loop_ew),
    .green(green_E),
    .cars (cars_ew),
    .queue(queue_ew),
    .fault(fault_ew)
  );

endmodule

// File: tb/tb_vehicle_demand_tracker.sv
// Directed testbench for vehicle_demand_tracker.
// DEBOUNCE 4, DEPART 5, QUEUE_MAX 15, STUCK 20.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_vehicle_demand_tracker;

  localparam int QW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          loop_ns;
  logic          loop_ew;
  logic          green_N;
  logic          green_E;
  logic          cars_ns;
  logic          cars_ew;
  logic [QW-1:0] queue_ns;
  logic [QW-1:0] queue_ew;
  logic          fault_ns;
  logic          fault_ew;

  int n_checks = 0;
  int n_pass   = 0;

  vehicle_demand_tracker #(
    .DEBOUNCE_CYCLES(4),
    .DEPART_CYCLES  (5),
    .QUEUE_MAX      (15),
    .STUCK_CYCLES   (20)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .loop_ns (loop_ns),
    .loop_ew (loop_ew),
    .green_N (green_N),
    .green_E (green_E),
    .cars_ns (cars_ns),
    .cars_ew (cars_ew),
    .queue_ns(queue_ns),
    .queue_ew(queue_ew),
    .fault_ns(fault_ns),
    .fault_ew(fault_ew)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    loop_ns = 1'b0;
    loop_ew = 1'b0;
    green_N = 1'b0;
    green_E = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic pulse(input bit ew, input int hi, input int lo);
    if (ew) loop_ew = 1'b1; else loop_ns = 1'b1;
    tick(hi);
    if (ew) loop_ew = 1'b0; else loop_ns = 1'b0;
    tick(lo);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cars_ns"},  int'(cars_ns),  0);
    check({tag, "_cars_ew"},  int'(cars_ew),  0);
    check({tag, "_queue_ns"}, int'(queue_ns), 0);
    check({tag, "_queue_ew"}, int'(queue_ew), 0);
    check({tag, "_fault_ns"}, int'(fault_ns), 0);
    check({tag, "_fault_ew"}, int'(fault_ew), 0);
  endtask

  int seen;

  initial begin
    rst     = 1'b1;
    loop_ns = 1'b0;
    loop_ew = 1'b0;
    green_N = 1'b0;
    green_E = 1'b0;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;

    // 1: latency of a held NS loop.
    loop_ns = 1'b1;
    tick(6);
    check("t1_cars_ns_e6",  int'(cars_ns),  0);
    check("t1_queue_ns_e6", int'(queue_ns), 0);
    tick(1);
    check("t1_cars_ns_e7",  int'(cars_ns),  1);
    check("t1_queue_ns_e7", int'(queue_ns), 1);
    check("t1_cars_ew",     int'(cars_ew),  0);
    check("t1_queue_ew",    int'(queue_ew), 0);

    // 2: a 3-cycle EW glitch is rejected.
    do_reset();
    loop_ew = 1'b1;
    tick(3);
    loop_ew = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen = seen | int'(cars_ew);
    end
    check("t2_cars_ew_never", seen, 0);
    check("t2_queue_ew",      int'(queue_ew), 0);

    // 3: five NS arrivals drained by green, with a mid-count freeze.
    do_reset();
    for (int i = 0; i < 5; i++) pulse(1'b0, 6, 6);
    check("t3_queue5", int'(queue_ns), 5);
    green_N = 1'b1;
    for (int s = 0; s < 2; s++) begin
      tick(4);
      check("t3_hold", int'(queue_ns), 5 - s);
      tick(1);
      check("t3_step", int'(queue_ns), 4 - s);
    end
    tick(2);
    green_N = 1'b0;
    tick(10);
    check("t3_freeze", int'(queue_ns), 3);
    green_N = 1'b1;
    tick(4);
    check("t3_dep_cleared", int'(queue_ns), 3);
    tick(1);
    check("t3_step_resume", int'(queue_ns), 2);
    for (int s = 0; s < 2; s++) begin
      tick(4);
      check("t3_hold2", int'(queue_ns), 2 - s);
      tick(1);
      check("t3_step2", int'(queue_ns), 1 - s);
      check("t3_cars",  int'(cars_ns), (s == 0) ? 1 : 0);
    end
    tick(10);
    check("t3_floor0", int'(queue_ns), 0);

    // 4: EW saturation and arrival coinciding with departure.
    do_reset();
    for (int i = 0; i < 15; i++) pulse(1'b1, 6, 6);
    check("t4_fill15", int'(queue_ew), 15);
    for (int i = 0; i < 3; i++) pulse(1'b1, 6, 6);
    check("t4_sat", int'(queue_ew), 15);
    loop_ew = 1'b1;
    tick(2);
    green_E = 1'b1;
    tick(4);
    check("t4_pre_coincide", int'(queue_ew), 15);
    loop_ew = 1'b0;
    tick(1);
    check("t4_coincide", int'(queue_ew), 15);
    tick(4);
    check("t4_hold", int'(queue_ew), 15);
    tick(1);
    check("t4_dep_alone", int'(queue_ew), 14);
    check("t4_queue_ns",  int'(queue_ns), 0);

    // 5: stuck NS sensor.
    do_reset();
    loop_ns = 1'b1;
    green_N = 1'b1;
    tick(7);
    check("t5_arrival", int'(queue_ns), 1);
    tick(5);
    check("t5_drained", int'(queue_ns), 0);
    tick(14);
    check("t5_fault_e26", int'(fault_ns), 0);
    check("t5_cars_e26",  int'(cars_ns),  0);
    tick(1);
    check("t5_fault_e27", int'(fault_ns), 1);
    check("t5_cars_e27",  int'(cars_ns),  1);
    check("t5_queue_e27", int'(queue_ns), 0);
    tick(20);
    check("t5_fault_hold", int'(fault_ns), 1);
    check("t5_fault_ew",   int'(fault_ew), 0);
    loop_ns = 1'b0;
    tick(6);
    check("t5_fault_r6", int'(fault_ns), 1);
    tick(1);
    check("t5_fault_r7", int'(fault_ns), 0);
    check("t5_cars_r7",  int'(cars_ns),  0);

    // 6: asynchronous reset mid-operation.
    do_reset();
    loop_ns = 1'b1;
    for (int i = 0; i < 3; i++) pulse(1'b1, 6, 6);
    green_E = 1'b1;
    tick(2);
    check("t6_pre_fault_ns", int'(fault_ns), 1);
    check("t6_pre_queue_ns", int'(queue_ns), 1);
    check("t6_pre_queue_ew", int'(queue_ew), 3);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    green_E = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(6);
    check("t6_queue_e6", int'(queue_ns), 0);
    check("t6_cars_e6",  int'(cars_ns),  0);
    tick(1);
    check("t6_queue_e7", int'(queue_ns), 1);
    check("t6_cars_e7",  int'(cars_ns),  1);
    check("t6_fault_e7", int'(fault_ns), 0);
    tick(8);
    check("t6_one_arrival", int'(queue_ns), 1);
    check("t6_queue_ew",    int'(queue_ew), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
